// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bit positions.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd7;
    localparam logic [3:0] OP_ADD1  = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_FLOOR = 4'd10;
    localparam logic [3:0] OP_SUB   = 4'd11;
    localparam logic [3:0] OP_SUB1  = 4'd12;
    localparam logic [3:0] OP_ROOF  = 4'd13;
    localparam logic [3:0] OP_MOD   = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    localparam int ZERO   = 0;
    localparam int CARRY  = 1;
    localparam int BORROW = 2;
    localparam int ERR    = 3;

    // Opcodes that use the iterative divider when the divisor is nonzero.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_FLOOR) || (op == OP_ROOF) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the register-read stage and the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic [3:0]       flags;

    modport master (
        output in_valid, alu_op, in_1, in_2, out_ready,
        input  in_ready, out_valid, alu_out, flags
    );

    modport slave (
        input  in_valid, alu_op, in_1, in_2, out_ready,
        output in_ready, out_valid, alu_out, flags
    );
endinterface

// File: rtl/div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle. The first step runs on
// the start edge directly from the inputs, so WIDTH steps end WIDTH-1 edges later.
module div_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH:0]   shifted, diff;

    // One restoring step; on start it operates on the fresh operands.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        shifted = {src_rem, src_quo[WIDTH-1]};
        diff    = shifted - {1'b0, src_dvs};
        // Partial remainder stays below the divisor, so bit WIDTH of diff is its sign.
        rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d   = {src_quo[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Step counter and busy flag; reset discards any in-flight divide.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(WIDTH - 1);
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    // Remainder/quotient shift registers advance only while steps remain.
    always_ff @(posedge clock) begin
        if (start || (busy_q && (cnt_q != '0))) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= src_dvs;
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arithmetic plus an iterative divider, behind
// valid/ready handshakes on both sides, with registered result and flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     clock,
    input  logic     reset_n,
    seq_alu_if.slave bus
);
    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] alu_out_q;
    logic [3:0]       flags_q;

    logic               div_start;
    logic               div_busy, div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;
    logic [WIDTH-1:0]   sc_res_d, div_res_d;
    logic [3:0]         sc_flags_d, div_flags_d;
    logic [WIDTH:0]     sum, inc;
    logic [2*WIDTH-1:0] prod;

    assign div_start = (state_q == IDLE) && bus.in_valid
                       && is_div_op(bus.alu_op) && (bus.in_2 != '0);

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (bus.in_1),
        .divisor   (bus.in_2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Single-cycle datapath, including the divide-by-zero results.
    always_comb begin
        sum        = {1'b0, bus.in_1} + {1'b0, bus.in_2};
        inc        = {1'b0, bus.in_1} + {{WIDTH{1'b0}}, 1'b1};
        prod       = {{WIDTH{1'b0}}, bus.in_1} * {{WIDTH{1'b0}}, bus.in_2};
        sc_res_d   = '0;
        sc_flags_d = '0;
        case (bus.alu_op)
            OP_ADD: begin
                sc_res_d          = sum[WIDTH-1:0];
                sc_flags_d[CARRY] = sum[WIDTH];
            end
            OP_ADD1: begin
                sc_res_d          = inc[WIDTH-1:0];
                sc_flags_d[CARRY] = inc[WIDTH];
            end
            OP_MUL: begin
                sc_res_d          = prod[WIDTH-1:0];
                sc_flags_d[CARRY] = |prod[2*WIDTH-1:WIDTH];
            end
            OP_SUB: begin
                sc_res_d           = bus.in_1 - bus.in_2;
                sc_flags_d[BORROW] = bus.in_1 < bus.in_2;
            end
            OP_SUB1: begin
                sc_res_d           = bus.in_1 - {{(WIDTH-1){1'b0}}, 1'b1};
                sc_flags_d[BORROW] = bus.in_1 == '0;
            end
            OP_FLOOR, OP_ROOF: begin
                sc_res_d        = '1;
                sc_flags_d[ERR] = 1'b1;
            end
            OP_MOD: begin
                sc_res_d        = bus.in_1;
                sc_flags_d[ERR] = 1'b1;
            end
            default: begin
                sc_res_d        = '0;
                sc_flags_d[ERR] = 1'b1;
            end
        endcase
        sc_flags_d[ZERO] = sc_res_d == '0;
    end

    // Divider post-processing: ceiling adjust for ROOF, remainder for MOD.
    always_comb begin
        div_flags_d = '0;
        case (op_q)
            OP_ROOF: div_res_d = div_quo + {{(WIDTH-1){1'b0}}, |div_rem};
            OP_MOD:  div_res_d = div_rem;
            default: div_res_d = div_quo;
        endcase
        div_flags_d[ZERO] = div_res_d == '0;
    end

    // Control FSM with the result and flag registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            alu_out_q <= '0;
            flags_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q <= bus.alu_op;
                        if (div_start) begin
                            state_q <= DIV;
                        end else begin
                            state_q   <= DONE;
                            alu_out_q <= sc_res_d;
                            flags_q   <= sc_flags_d;
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state_q   <= DONE;
                        alu_out_q <= div_res_d;
                        flags_q   <= div_flags_d;
                    end else if (!div_busy) begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.alu_out   = alu_out_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=16: single-cycle ops, divides, div-by-zero,
// backpressure, back-to-back throughput and reset behaviour.
module tb_seq_alu;
    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    seq_alu_if #(.WIDTH(16)) bus();

    seq_alu #(.WIDTH(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Present one operation for a single edge; caller ensures the ALU is idle.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.alu_op   = op;
        bus.in_1     = a;
        bus.in_2     = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [21:0] got;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_op   = 4'd0;
        bus.in_1     = 16'h0;
        bus.in_2     = 16'h0;
        tick();
        tick();
        got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
        checks++;
        if (got !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, {1'b1, 1'b0, 16'h0000, 4'b0000});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [3:0]  ops [13] = '{4'd7, 4'd11, 4'd11, 4'd9, 4'd8, 4'd12, 4'd7,
                                  4'd9, 4'd10, 4'd13, 4'd14, 4'd0, 4'd15};
        logic [15:0] as  [13] = '{16'hFFFF, 16'h0005, 16'h0009, 16'h0100, 16'hFFFF, 16'h0000, 16'h1234,
                                  16'h0003, 16'h1234, 16'h1234, 16'h1234, 16'h0005, 16'h0005};
        logic [15:0] bs  [13] = '{16'h0001, 16'h0009, 16'h0009, 16'h0100, 16'h0000, 16'h0000, 16'h1111,
                                  16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0003};
        logic [15:0] eo  [13] = '{16'h0000, 16'hFFFC, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h2345,
                                  16'h000F, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000};
        logic [3:0]  ef  [13] = '{4'b0011, 4'b0100, 4'b0001, 4'b0011, 4'b0011, 4'b0100, 4'b0000,
                                  4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1001};
        logic [21:0] got, exp;
        for (int i = 0; i < 13; i++) begin
            issue(ops[i], as[i], bs[i]);
            got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
            exp = {1'b0, 1'b1, eo[i], ef[i]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_vec%0d op=%0d: got %h expected %h", i, ops[i], got, exp);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_divide;
        logic [3:0]  ops [8] = '{4'd10, 4'd13, 4'd14, 4'd13, 4'd10, 4'd14, 4'd10, 4'd13};
        logic [15:0] as  [8] = '{16'd100, 16'd100, 16'd100, 16'd14, 16'hFFFF, 16'hFFFF, 16'd3, 16'd3};
        logic [15:0] bs  [8] = '{16'd7, 16'd7, 16'd7, 16'd7, 16'h0001, 16'h0010, 16'd7, 16'd7};
        logic [15:0] eo  [8] = '{16'd14, 16'd15, 16'd2, 16'd2, 16'hFFFF, 16'h000F, 16'd0, 16'd1};
        logic [3:0]  ef  [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        logic [21:0] got, exp;
        int          bad_at;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i]);
            // Operands were latched at the accept edge; disturb them.
            bus.in_1 = 16'h0000;
            bus.in_2 = 16'h0000;
            bad_at = 0;
            for (int k = 1; k <= 16; k++) begin
                if ((bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) && bad_at == 0) bad_at = k;
                tick();
            end
            checks++;
            if (bad_at != 0) begin
                errors++;
                $display("FAIL div_wait%0d: handshake active at cycle N+%0d, expected out_valid=0 in_ready=0 until N+17", i, bad_at);
            end
            got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
            exp = {1'b0, 1'b1, eo[i], ef[i]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL div_result%0d op=%0d: got %h expected %h", i, ops[i], got, exp);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        logic [21:0] got;
        int          bad_at;
        issue(4'd7, 16'd2, 16'd3);
        bad_at = 0;
        for (int k = 1; k <= 5; k++) begin
            got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
            if (got !== {1'b0, 1'b1, 16'h0005, 4'b0000} && bad_at == 0) bad_at = k;
            tick();
        end
        checks++;
        if (bad_at != 0) begin
            errors++;
            $display("FAIL backpressure_hold: unstable at stall cycle %0d, expected ready=0 valid=1 out=0005 flags=0", bad_at);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
        checks++;
        if (got !== {1'b1, 1'b0, 16'h0005, 4'b0000}) begin
            errors++;
            $display("FAIL backpressure_release: got %h expected %h", got, {1'b1, 1'b0, 16'h0005, 4'b0000});
        end
    endtask

    task automatic test_back_to_back;
        logic [21:0] got;
        bus.out_ready = 1'b1;
        bus.alu_op    = 4'd7;
        bus.in_1      = 16'd1;
        bus.in_2      = 16'd1;
        bus.in_valid  = 1'b1;
        tick();
        got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
        checks++;
        if (got !== {1'b0, 1'b1, 16'h0002, 4'b0000}) begin
            errors++;
            $display("FAIL b2b_first: got %h expected %h", got, {1'b0, 1'b1, 16'h0002, 4'b0000});
        end
        bus.in_2 = 16'd2;
        tick();
        got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
        checks++;
        if (got !== {1'b1, 1'b0, 16'h0002, 4'b0000}) begin
            errors++;
            $display("FAIL b2b_gap: got %h expected %h", got, {1'b1, 1'b0, 16'h0002, 4'b0000});
        end
        tick();
        got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
        checks++;
        if (got !== {1'b0, 1'b1, 16'h0003, 4'b0000}) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", got, {1'b0, 1'b1, 16'h0003, 4'b0000});
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_div;
        logic [21:0] got;
        int          bad_at;
        issue(4'd10, 16'd100, 16'd7);
        for (int k = 0; k < 7; k++) tick();
        reset_n = 1'b0;
        tick();
        got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
        checks++;
        if (got !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_div: got %h expected %h", got, {1'b1, 1'b0, 16'h0000, 4'b0000});
        end
        reset_n = 1'b1;
        tick();
        bad_at = 0;
        for (int k = 1; k <= 20; k++) begin
            if ((bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) && bad_at == 0) bad_at = k;
            tick();
        end
        checks++;
        if (bad_at != 0) begin
            errors++;
            $display("FAIL reset_discard: divide resurfaced at cycle %0d after release, expected idle", bad_at);
        end
        issue(4'd7, 16'd2, 16'd3);
        got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
        checks++;
        if (got !== {1'b0, 1'b1, 16'h0005, 4'b0000}) begin
            errors++;
            $display("FAIL post_reset_add: got %h expected %h", got, {1'b0, 1'b1, 16'h0005, 4'b0000});
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_vs_valid;
        logic [21:0] got;
        bus.alu_op   = 4'd7;
        bus.in_1     = 16'd1;
        bus.in_2     = 16'd1;
        bus.in_valid = 1'b1;
        reset_n      = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        got = {bus.in_ready, bus.out_valid, bus.alu_out, bus.flags};
        checks++;
        if (got !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
            errors++;
            $display("FAIL reset_beats_valid: got %h expected %h", got, {1'b1, 1'b0, 16'h0000, 4'b0000});
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_divide();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        test_reset_vs_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
